// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// Auto-play scheduler: walks song entries in a synchronous ROM, holds each note, inserts gaps.
// Define SONG_SEQUENCER_LOOP_EN to repeat the song until stop instead of ending in DONE.
module song_sequencer #(
    parameter int TICKS_PER_UNIT = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter int ADDR_W         = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic [2:0]            song_sel,
    output logic [3+ADDR_W-1:0]   rom_addr,
    input  logic [9:0]            rom_data,
    output logic [3:0]            note_out,
    output logic [1:0]            octave_out,
    output logic [6:0]            led_out,
    output logic [3:0]            num,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
`ifdef SONG_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_UNIT - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [2:0]          song_q, song_d;
    logic [3:0]          note_q, note_d;
    logic [1:0]          oct_q, oct_d;
    logic [3:0]          units_q, units_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [3:0]          note_out_q, note_out_d;
    logic [1:0]          octave_out_q, octave_out_d;
    logic [6:0]          led_out_q, led_out_d;
    logic [3:0]          num_q, num_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                marker, active, entry_end;

    function automatic logic [6:0] note_led(input logic [3:0] n);
        note_led = (n == 4'd0) ? 7'd0 : 7'(7'd1 << (n - 4'd1));
    endfunction

    assign marker = (rom_data[3:0] == 4'd0) || (rom_data[7:4] > 4'd7);
    assign active = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rom_addr = active ? {song_q, index_q} : '0;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        song_d    = song_q;
        note_d    = note_q;
        oct_d     = oct_q;
        units_d   = units_q;
        tick_d    = tick_q;
        gap_d     = gap_q;
        entry_end = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    song_d  = song_sel;
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (marker) begin
                    index_d = '0;
                    state_d = LOOP ? S_FETCH : S_DONE;
                end else begin
                    oct_d   = rom_data[9:8];
                    note_d  = rom_data[7:4];
                    units_d = rom_data[3:0];
                    tick_d  = TICK_RELOAD;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TW'(1);
                    end else if (units_q != 4'd1) begin
                        units_d = units_q - 4'd1;
                        tick_d  = TICK_RELOAD;
                    end else if (GAP_TICKS == 0) begin
                        entry_end = 1'b1;
                    end else begin
                        gap_d   = GAP_RELOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (gap_q != '0) gap_d = gap_q - GW'(1);
                    else             entry_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The last entry of a song never rolls over into the next song's address range.
        if (entry_end) begin
            if (index_q == '1) begin
                index_d = '0;
                state_d = LOOP ? S_FETCH : S_DONE;
            end else begin
                index_d = index_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end
        if (stop) begin
            state_d = S_IDLE;
            index_d = '0;
        end
    end

    // Outputs are registered views of the state in the cycle just ended.
    always_comb begin
        note_out_d   = '0;
        octave_out_d = '0;
        led_out_d    = '0;
        num_d        = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        if (!stop) begin
            busy_d = active;
            done_d = (state_q == S_DONE);
            if (active) begin
                num_d        = 4'(index_q);
                octave_out_d = octave_out_q;
            end
            if (state_q == S_PLAY) begin
                octave_out_d = oct_q;
                if (!pause) begin
                    note_out_d = note_q;
                    led_out_d  = note_led(note_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            song_q       <= '0;
            note_q       <= '0;
            oct_q        <= '0;
            units_q      <= '0;
            tick_q       <= '0;
            gap_q        <= '0;
            note_out_q   <= '0;
            octave_out_q <= '0;
            led_out_q    <= '0;
            num_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            song_q       <= song_d;
            note_q       <= note_d;
            oct_q        <= oct_d;
            units_q      <= units_d;
            tick_q       <= tick_d;
            gap_q        <= gap_d;
            note_out_q   <= note_out_d;
            octave_out_q <= octave_out_d;
            led_out_q    <= led_out_d;
            num_q        <= num_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign note_out   = note_out_q;
    assign octave_out = octave_out_q;
    assign led_out    = led_out_q;
    assign num        = num_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
// Bench for song_sequencer: queue-based timeline model of song playback, randomized controls.
module tb_song_sequencer;

    localparam int TPU = 4;
    localparam int GAP = 2;
`ifdef SONG_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    localparam logic [1:0] K_FL = 2'd0, K_PLAY = 2'd1, K_GAP = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] song_sel = 3'd0;
    logic [8:0] rom_addr;
    logic [9:0] rom_data = 10'd0;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [3:0] num;
    logic       busy;
    logic       done;

    logic [9:0] mem [0:511];

    song_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(GAP), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_out(note_out), .octave_out(octave_out), .led_out(led_out),
        .num(num), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] note;
        logic [1:0] oct;
        logic [5:0] idx;
    } rec_t;

    rec_t       q[$];
    int         mode = M_IDLE;
    logic [2:0] cur_song = 3'd0;
    logic [1:0] last_oct = 2'd0;
    logic [3:0] e_note, e_num;
    logic [1:0] e_oct;
    logic [6:0] e_led;
    logic       e_busy, e_done;
    logic [8:0] e_addr;
    logic [8:0] max_addr = 9'd0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_rec(input logic [1:0] k, input logic [3:0] n,
                                     input logic [1:0] o, input int i);
        rec_t r;
        r.kind = k; r.note = n; r.oct = o; r.idx = 6'(i);
        q.push_back(r);
    endfunction

    // Timeline of one pass through a song: 2 silent fetch cycles per entry, note, then gap.
    function automatic void build_song(input logic [2:0] s);
        logic [9:0] e;
        q.delete();
        for (int i = 0; i < 64; i++) begin
            e = mem[{s, 6'(i)}];
            push_rec(K_FL, 4'd0, 2'd0, i);
            push_rec(K_FL, 4'd0, 2'd0, i);
            if (e[3:0] == 4'd0 || e[7:4] > 4'd7) return;
            repeat (int'(e[3:0]) * TPU) push_rec(K_PLAY, e[7:4], e[9:8], i);
            repeat (GAP) push_rec(K_GAP, 4'd0, 2'd0, i);
        end
    endfunction

    function automatic void model_edge();
        rec_t r;
        e_note = 4'd0; e_oct = 2'd0; e_led = 7'd0; e_num = 4'd0; e_busy = 1'b0; e_done = 1'b0;
        r = '0;
        if (mode == M_RUN) r = q[0];
        if (!stop) begin
            if (mode == M_DONE) e_done = 1'b1;
            else if (mode == M_RUN) begin
                e_busy = 1'b1;
                e_num  = r.idx[3:0];
                if (r.kind == K_PLAY) begin
                    e_oct = r.oct;
                    last_oct = r.oct;
                    if (!pause) begin
                        e_note = r.note;
                        e_led  = (r.note == 4'd0) ? 7'd0 : 7'(7'd1 << (r.note - 4'd1));
                    end
                end else begin
                    e_oct = last_oct;
                end
            end
        end
        if (stop) begin
            mode = M_IDLE;
            q.delete();
        end else if (mode == M_RUN) begin
            if (!(pause && r.kind != K_FL)) void'(q.pop_front());
            if (q.size() == 0) begin
                if (LOOP) build_song(cur_song);
                else      mode = M_DONE;
            end
        end else if (start) begin
            cur_song = song_sel;
            last_oct = 2'd0;
            build_song(song_sel);
            mode = M_RUN;
        end
        e_addr = (mode == M_RUN) ? {cur_song, q[0].idx} : 9'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("outs", 32'({note_out, octave_out, led_out, num, busy, done}),
                  32'({e_note, e_oct, e_led, e_num, e_busy, e_done}));
        check_val("rom_addr", 32'(rom_addr), 32'(e_addr));
        if (rom_addr > max_addr) max_addr = rom_addr;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, cnt, found;
        for (int i = 0; i < 512; i++) mem[i] = 10'd0;
        mem[9'h040] = {2'd1, 4'd3, 4'd2};
        mem[9'h041] = {2'd0, 4'd5, 4'd1};
        for (int i = 0; i < 10; i++)
            mem[{3'd0, 6'(i)}] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 4'($urandom_range(1, 3))};
        for (int i = 0; i < 64; i++)
            mem[{3'd2, 6'(i)}] = {2'($urandom_range(0, 3)), 4'($urandom_range(1, 7)), 4'd1};
        for (int i = 0; i < 6; i++)
            mem[{3'd3, 6'(i)}] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 4'($urandom_range(1, 2))};
        mem[{3'd3, 6'd6}] = {2'd2, 4'd9, 4'd2};

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outs", 32'({note_out, octave_out, led_out, num, busy, done, rom_addr}), 32'd0);
        reset = 1'b1;

        // Directed song 1 from idle.
        start = 1'b1; song_sel = 3'd1;
        step();
        check_val("rom_addr_edge0", 32'(rom_addr), 32'h40);
        start = 1'b0;
        repeat (3) step();
        check_val("first_note", 32'({note_out, octave_out, led_out}), 32'({4'd3, 2'd1, 7'b0000100}));
        for (int i = 0; i < 40; i++) begin
            step();
            if (!LOOP && done) break;
        end
        check_val("song1_done", 32'(done), LOOP ? 32'd0 : 32'd1);

        // Pause with 5 ticks of note 3 left.
        go_idle();
        start = 1'b1; song_sel = 3'd1;
        step();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            step();
            if (note_out == 4'd3) seen++;
        end
        check_val("pre_pause_cnt", 32'(seen), 32'd3);
        pause = 1'b1;
        repeat (10) begin
            step();
            check_val("paused_note", 32'({note_out, led_out}), 32'd0);
        end
        pause = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (note_out == 4'd3) cnt++;
        end
        check_val("resume_len", 32'(cnt), 32'd5);

        // Stop during PLAY, then stop together with start.
        go_idle();
        start = 1'b1; song_sel = 3'd1;
        step();
        start = 1'b0;
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("stop_outs", 32'({note_out, led_out, busy, rom_addr}), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check_val("stop_start_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check_val("no_restart", 32'({busy, rom_addr}), 32'd0);

        // Asynchronous reset in the middle of a gap.
        go_idle();
        start = 1'b1; song_sel = 3'd1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            step();
            if (mode == M_RUN && q.size() > 0 && q[0].kind == K_GAP) found = 1;
        end
        check_val("gap_reached", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1 check_val("async_rst", 32'({note_out, octave_out, led_out, num, busy, done, rom_addr}), 32'd0);
        mode = M_IDLE;
        q.delete();
        last_oct = 2'd0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) step();

        // 64-entry song without end marker.
        go_idle();
        max_addr = 9'd0;
        start = 1'b1; song_sel = 3'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (!LOOP && done) break;
        end
        check_val("song2_done", 32'(done), LOOP ? 32'd0 : 32'd1);
        check_val("song2_max_addr", 32'(max_addr), 32'({3'd2, 6'h3F}));

        // Randomized controls against the timeline model.
        go_idle();
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            song_sel = 3'($urandom_range(0, 7));
            if (cnt > 0) begin
                pause = 1'b1;
                cnt--;
            end else begin
                pause = 1'b0;
                if ($urandom_range(0, 39) == 0) cnt = $urandom_range(1, 12);
            end
            step();
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Auto-play scheduler that drives the note/octave inputs of the buzzer and the LED and 7-segment display paths.
- Steps through song entries in an external synchronous song ROM, holding each note for its encoded duration and inserting a silent gap between notes.
- Supports start, pause, stop and song selection; sits between the mode/button logic and the buzzer.

Parameters:
- TICKS_PER_UNIT, 12_500_000, clk cycles per duration unit (1/8 s at 100 MHz); must be >= 1
- GAP_TICKS, 1_250_000, silent clk cycles inserted after every note; 0 means no gap
- ADDR_W, 6, entry-index width per song (64 entries max)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begin playing the selected song
- pause  in  1  level; freeze playback while high
- stop  in  1  single-cycle pulse; abort playback and return to idle
- song_sel  in  3  song number, latched on accepted start
- rom_addr  out  3+ADDR_W  {latched song, entry index}
- rom_data  in  10  {octave[1:0], note[3:0], dur[3:0]}, valid one cycle after rom_addr
- note_out  out  4  note to buzzer; 0 = silence
- octave_out  out  2  octave to buzzer
- led_out  out  7  one-hot of the sounding note
- num  out  4  current entry index [3:0] for the segment display
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE

Behaviour:
- Reset (reset=0, async): state IDLE; index=0; all outputs 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE/DONE + start:
  - latch song_sel; index=0; go to FETCH.
  - start while busy is ignored.
- FETCH (1 cycle): rom_addr={song,index}; go to LOAD.
- LOAD (1 cycle): capture rom_data.
  - If dur==0, or note>7: end-of-song marker; go to DONE.
  - Otherwise go to PLAY; load unit counter=TICKS_PER_UNIT-1 and units=dur.
- Latency: start sampled at edge k gives note_out valid after edge k+3.
- PLAY:
  - note_out=note; octave_out=octave; led_out bit (note-1) set (all 0 for note 0 = rest).
  - Tick counter decrements every cycle.
  - On 0: units-1 and reload counter; when units reaches 0, the note ends.
  - Note length is exactly dur*TICKS_PER_UNIT cycles, then go to GAP (or FETCH if GAP_TICKS==0).
- GAP:
  - note_out=0 and led_out=0; octave_out holds.
  - Lasts GAP_TICKS cycles, then index+1 and go to FETCH.
- Index wrap: after entry 2^ADDR_W-1 completes, go to DONE; index never wraps into the next song.
- pause=1 in PLAY/GAP:
  - counters freeze; note_out and led_out forced 0.
  - On release, playback resumes with remaining count intact.
  - pause has no effect in FETCH/LOAD until the next PLAY/GAP.
- stop:
  - From any state: go to IDLE next edge; all outputs 0; index=0.
  - stop and start in the same cycle: stop wins.
- DONE: outputs 0 except done=1; a start replays.
- num tracks index in all busy states; 0 in IDLE.
- song_sel changes while busy are ignored until the next start.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
  - Defined: an end-of-song marker or index wrap returns to FETCH with index=0, so the song repeats until stop; done never asserts.
  - Undefined: behaviour as above, ending in DONE.

Test Plan:
- Params TICKS_PER_UNIT=4, GAP_TICKS=2; song 1 entries {1,3,2},{0,5,1},{0,0,0}; start at edge 0:
  - rom_addr=0x40 after edge 0.
  - note_out=3, octave_out=1, led_out=7'b0000100 from edge 3 for 8 cycles.
  - note_out=0 for 2 cycles, then note 5 for 4 cycles, gap, then done=1.
- pause=1 for 10 cycles mid-PLAY with 5 ticks remaining -> note_out=0 while paused; after release note 3 resumes for exactly 5 cycles.
- stop pulse during PLAY, and stop+start in the same cycle -> IDLE next edge, all outputs 0, busy=0; no restart.
- Assert reset low mid-GAP (asynchronously, between edges) -> outputs 0 immediately; after release stays IDLE until start.
- Song of 64 non-zero entries with ADDR_W=6 -> DONE after entry 63; rom_addr never exceeds {song,6'h3F}.
- With SONG_SEQUENCER_LOOP_EN defined, the song from the first scenario -> after the second note and gap, rom_addr returns to 0x40 and note 3 replays; done stays 0.
